// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory watchdog
// Optional JUMP_EN macro adds the j instruction (opcode 000010) and its JUMP state.
module multicycle_control #(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ALU_src_a,
  output logic [1:0] ALU_src_b,
  output logic [1:0] ALU_op,
  output logic [3:0] state_out,
  output logic       instr_retired,
  output logic       illegal,
  output logic       bus_error
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_ADDI_EXEC = 4'd9;
  localparam logic [3:0] S_ADDI_WB   = 4'd10;
`ifdef JUMP_EN
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [5:0] OP_J        = 6'b000010;
`endif
  localparam logic [3:0] S_TRAP      = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int              CW        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = '1;
  localparam logic [CW-1:0]   CNT_LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          illegal_q, illegal_d;
  logic          bus_error_q, bus_error_d;
  logic          op_illegal;
  logic          wd_expire;
  logic          in_mem_wait;

  always_comb begin
    op_illegal = 1'b1;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: op_illegal = 1'b0;
`ifdef JUMP_EN
      OP_J:                                    op_illegal = 1'b0;
`endif
      default:                                 op_illegal = 1'b1;
    endcase
  end

  assign in_mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // ready on the limit cycle still completes the handshake
  assign wd_expire   = (MEM_TIMEOUT != 0) && in_mem_wait && !mem_ready && (wait_cnt_q == CNT_LIMIT);

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    case (state_q)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = (state_q == S_FETCH)    ? S_DECODE :
                    (state_q == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        end else if (wd_expire) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (op_illegal) begin
          if (TRAP_ON_ILLEGAL) begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          case (opcode)
            OP_RTYPE:     state_d = S_R_EXEC;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDI_EXEC;
`ifdef JUMP_EN
            OP_J:         state_d = S_JUMP;
`endif
            default:      state_d = S_TRAP;
          endcase
        end
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB: state_d = S_FETCH;
`ifdef JUMP_EN
      S_JUMP:      state_d = S_FETCH;
`endif
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (in_mem_wait && !mem_ready && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // outputs are held at 0 for as long as reset is asserted
  always_comb begin
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    ALU_src_a     = 1'b0;
    ALU_src_b     = 2'b00;
    ALU_op        = 2'b00;
    instr_retired = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          ALU_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          ALU_src_b     = 2'b11;
          instr_retired = op_illegal && !TRAP_ON_ILLEGAL;
        end
        S_MEM_ADDR: begin
          ALU_src_a = 1'b1;
          ALU_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write     = 1'b1;
          mem_to_reg    = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write     = 1'b1;
          i_or_d        = 1'b1;
          instr_retired = mem_ready;
        end
        S_R_EXEC: begin
          ALU_src_a = 1'b1;
          ALU_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write     = 1'b1;
          reg_dst       = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          ALU_src_a     = 1'b1;
          ALU_op        = 2'b01;
          pc_src        = 2'b01;
          pc_write      = zero;
          instr_retired = 1'b1;
        end
        S_ADDI_EXEC: begin
          ALU_src_a = 1'b1;
          ALU_src_b = 2'b10;
        end
        S_ADDI_WB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
`ifdef JUMP_EN
        S_JUMP: begin
          pc_write      = 1'b1;
          pc_src        = 2'b10;
          instr_retired = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state_out = rst_n ? state_q : 4'd0;
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle control FSM for the MIPS core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives the execute stage's ALU_op/ALU_src-style selects, the PC, IR, memory and register-file enables. Memory accesses use a ready handshake with a watchdog timeout. Sits beside the datapath; the opcode comes from the IR, zero comes from the ALU.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles per memory access before trapping; 0 disables the watchdog.
TRAP_ON_ILLEGAL, 1, 1: an illegal opcode enters TRAP; 0: it retires as a NOP.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  PC load enable
pc_src  out  2  00 ALU result, 01 branch-target register, 10 jump target
i_or_d  out  1  memory address select: 0 PC, 1 ALU-out
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
reg_write  out  1  register-file write enable
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  writeback select: 0 ALU, 1 MDR
ALU_src_a  out  1  0 PC, 1 rs
ALU_src_b  out  2  00 rt, 01 constant 4, 10 extended_offset, 11 extended_offset<<2
ALU_op  out  2  00 add, 01 sub, 10 decode funct
state_out  out  4  current state encoding
instr_retired  out  1  one-cycle pulse on an instruction's final cycle
illegal  out  1  sticky, illegal opcode trapped
bus_error  out  1  sticky, memory timeout trapped

Behaviour:
- Reset (async, rst_n=0): state=FETCH, wait_cnt=0, illegal=0, bus_error=0. Every output forced 0 while rst_n=0. First FETCH cycle is the first edge after release.
- All outputs are Moore, decoded from state, except these, which are combinational on the current cycle: pc_write/ir_write in FETCH (on mem_ready), pc_write in BRANCH (on zero), instr_retired. Any signal not listed for a state is 0.
- States (encoding) and outputs:
  - FETCH(0): mem_read=1, i_or_d=0, src_a=0, src_b=01, op=00. Holds while mem_ready=0. On mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - DECODE(1): src_a=0, src_b=11, op=00. Dispatch on opcode: 000000 to R_EXEC; 100011/101011 to MEM_ADDR; 000100 to BRANCH; 001000 to ADDI_EXEC; 000010 to JUMP (macro only); anything else is illegal.
  - MEM_ADDR(2): src_a=1, src_b=10, op=00. lw goes to MEM_READ, sw goes to MEM_WRITE (decided on the opcode input, which stays stable).
  - MEM_READ(3): mem_read=1, i_or_d=1. Goes to MEM_WB on mem_ready.
  - MEM_WB(4): reg_write=1, reg_dst=0, mem_to_reg=1, retire, go to FETCH.
  - MEM_WRITE(5): mem_write=1, i_or_d=1. On mem_ready: retire, go to FETCH.
  - R_EXEC(6): src_a=1, src_b=00, op=10, go to R_WB.
  - R_WB(7): reg_write=1, reg_dst=1, retire, go to FETCH.
  - BRANCH(8): src_a=1, src_b=00, op=01, pc_src=01, pc_write=zero, retire, go to FETCH.
  - ADDI_EXEC(9): src_a=1, src_b=10, op=00, go to ADDI_WB.
  - ADDI_WB(10): reg_write=1, reg_dst=0, retire, go to FETCH.
  - JUMP(11): pc_write=1, pc_src=10, retire, go to FETCH.
  - TRAP(15): all enables 0. Held until reset.
- Latency in cycles with zero memory wait: R=4, addi=4, beq=3, j=3, sw=4, lw=5. Each memory wait cycle adds 1.
- Illegal opcode in DECODE:
  - TRAP_ON_ILLEGAL=1: set illegal, go to TRAP.
  - TRAP_ON_ILLEGAL=0: pulse instr_retired, go to FETCH.
- Watchdog:
  - wait_cnt is cleared on entry to FETCH, MEM_READ or MEM_WRITE.
  - It increments each cycle in those states while mem_ready=0.
  - If mem_ready=0 and wait_cnt==MEM_TIMEOUT-1: set bus_error, go to TRAP.
  - If mem_ready=1 on that same cycle, the handshake completes normally (ready wins).
  - Counter width is clog2(MEM_TIMEOUT+1); it saturates and never wraps.
- mem_read and mem_write are never both 1. reg_write and pc_write are never both 1.

Optional Feature:
Macro JUMP_EN.
- Defined: opcode 000010 dispatches to JUMP(11).
- Undefined: JUMP is not synthesised; 000010 is treated as illegal per TRAP_ON_ILLEGAL.

Test Plan:
- R-type add, mem_ready=1 on first FETCH cycle -> state_out 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. ALU_op=10 in state 6. instr_retired pulses once.
- lw, mem_ready held low 3 cycles in MEM_READ -> state 3 held 4 cycles, then 4. mem_to_reg=1 in 4. Total 8 cycles.
- beq with zero=1 -> pc_write=1 and pc_src=01 in state 8. Repeat with zero=0 -> pc_write=0. Both return to FETCH.
- MEM_TIMEOUT=16, mem_ready stuck 0 in FETCH -> TRAP after exactly 16 FETCH cycles, bus_error=1, outputs 0. Rerun with mem_ready=1 on the 16th cycle -> no trap.
- opcode 111111 with TRAP_ON_ILLEGAL=1 -> state 15, illegal=1. Assert rst_n=0 mid-TRAP -> all outputs 0 immediately; after release, state_out=0 and flags cleared.
- opcode 000010 with JUMP_EN -> state 11, pc_write=1, pc_src=10. Without the macro -> illegal=1.
